// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage and its neighbours.
package writeback_pkg;

    // Writeback sequencing states.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    // Load funct3 encodings.
    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    // Major opcodes shared across the pipeline.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // True for the five funct3 codes a load may legally carry.
    function automatic logic is_legal_load(input logic [2:0] funct3);
        case (funct3)
            LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU: is_legal_load = 1'b1;
            default:                                        is_legal_load = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/writeback_if.sv
// Execute-side retire bundle, data-memory response and register-file write port.
interface writeback_if #(
    parameter int WORD_SIZE = 32
) ();

    logic                 ex_valid;
    logic                 ex_ready;
    logic [WORD_SIZE-1:0] ex_result;
    logic [4:0]           ex_reg_dest;
    logic                 ex_write_enable;
    logic                 ex_is_load;
    logic [2:0]           ex_funct3;
    logic [1:0]           ex_addr_low;
    logic                 mem_rsp_valid;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 write_enable;
    logic [4:0]           write_addr;
    logic [WORD_SIZE-1:0] write_data;
    logic                 load_error;

    // Writeback stage side.
    modport slave (
        input  ex_valid, ex_result, ex_reg_dest, ex_write_enable, ex_is_load,
               ex_funct3, ex_addr_low, mem_rsp_valid, mem_rdata,
        output ex_ready, write_enable, write_addr, write_data, load_error
    );

    // Execute / memory / register-file side.
    modport master (
        output ex_valid, ex_result, ex_reg_dest, ex_write_enable, ex_is_load,
               ex_funct3, ex_addr_low, mem_rsp_valid, mem_rdata,
        input  ex_ready, write_enable, write_addr, write_data, load_error
    );

endinterface

// File: rtl/writeback_load_formatter.sv
// Aligns a data-memory read word and sign/zero-extends it by load width.
module load_formatter
    import writeback_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] rdata,
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr_low,
    output logic [WORD_SIZE-1:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte/half, then extend according to funct3.
    always_comb begin
        sel_byte = rdata[8*addr_low +: 8];
        sel_half = rdata[16*addr_low[1] +: 16];
        result   = '0;
        case (funct3)
            LOAD_LB:  result = {{(WORD_SIZE-8){sel_byte[7]}}, sel_byte};
            LOAD_LBU: result = {{(WORD_SIZE-8){1'b0}}, sel_byte};
            LOAD_LH:  result = {{(WORD_SIZE-16){sel_half[15]}}, sel_half};
            LOAD_LHU: result = {{(WORD_SIZE-16){1'b0}}, sel_half};
            LOAD_LW:  result = rdata;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: retires ALU results directly, waits for load data,
// formats it and drives the register-file write port.
module writeback
    import writeback_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    writeback_if.slave wb
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    wb_state_t            state;
    logic [CNT_W-1:0]     counter;
    logic [4:0]           lat_dest;
    logic                 lat_we;
    logic [2:0]           lat_funct3;
    logic [1:0]           lat_addr_low;
    logic                 write_enable_q;
    logic [4:0]           write_addr_q;
    logic [WORD_SIZE-1:0] write_data_q;
    logic                 load_error_q;
    logic [WORD_SIZE-1:0] formatted;

    load_formatter #(
        .WORD_SIZE(WORD_SIZE)
    ) u_fmt (
        .rdata   (wb.mem_rdata),
        .funct3  (lat_funct3),
        .addr_low(lat_addr_low),
        .result  (formatted)
    );

    // Retire sequencing, load tracking with timeout, and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            lat_dest       <= '0;
            lat_we         <= 1'b0;
            lat_funct3     <= '0;
            lat_addr_low   <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            load_error_q   <= 1'b0;
        end else begin
            write_enable_q <= 1'b0;
            load_error_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb.ex_valid) begin
                        if (!wb.ex_is_load) begin
                            write_enable_q <= wb.ex_write_enable & (wb.ex_reg_dest != 5'd0);
                            write_addr_q   <= wb.ex_reg_dest;
                            write_data_q   <= wb.ex_result;
                        end else if (!is_legal_load(wb.ex_funct3)) begin
                            load_error_q <= 1'b1;
                        end else begin
                            lat_dest     <= wb.ex_reg_dest;
                            lat_we       <= wb.ex_write_enable;
                            lat_funct3   <= wb.ex_funct3;
                            lat_addr_low <= wb.ex_addr_low;
                            counter      <= '0;
                            state        <= WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    // A response in the limit cycle takes priority over the timeout.
                    if (wb.mem_rsp_valid) begin
                        write_enable_q <= lat_we & (lat_dest != 5'd0);
                        write_addr_q   <= lat_dest;
                        write_data_q   <= formatted;
                        state          <= IDLE;
                    end else if (counter == CNT_LIMIT) begin
                        load_error_q <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready depends on state only, so there is no input-to-ready path.
    always_comb begin
        wb.ex_ready     = (state == IDLE);
        wb.write_enable = write_enable_q;
        wb.write_addr   = write_addr_q;
        wb.write_data   = write_data_q;
        wb.load_error   = load_error_q;
    end

endmodule
